// File: rtl/fadd_issue_pkg.sv
// Shared types for the FPU adder issue stage.
// Fields marked exc exist only when FADD_ISSUE_EXC_EN is defined.
package fadd_issue_pkg;

  localparam int PKG_TAG_W = 5;
  localparam logic [7:0] EXP_MAX = 8'hFF;

  typedef enum logic [1:0] {
    OP_FADD = 2'b00,
    OP_FSUB = 2'b01,
    OP_FNEG = 2'b10,
    OP_FABS = 2'b11
  } op_e;

  typedef struct packed {
    logic                 valid;
    logic [PKG_TAG_W-1:0] tag;
    logic                 bypass;
    logic [31:0]          local_result;
`ifdef FADD_ISSUE_EXC_EN
    logic                 exc;
`endif
  } dl_entry_t;

  typedef struct packed {
    logic [PKG_TAG_W-1:0] tag;
    logic [31:0]          result;
`ifdef FADD_ISSUE_EXC_EN
    logic                 exc;
`endif
  } buf_entry_t;

  function automatic logic exp_is_max(input logic [31:0] f);
    return f[30:23] == EXP_MAX;
  endfunction

endpackage

// File: rtl/fadd_issue_fifo.sv
// Generic synchronous FIFO with registered storage and combinational head.
// DEPTH must be a power of two; push is unguarded, callers must never push when full.
module fadd_issue_fifo #(
  parameter int  DEPTH = 4,
  parameter type T     = logic [7:0]
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  T     din,
  input  logic pop,
  output T     dout,
  output logic full,
  output logic empty
);

  localparam int AW = $clog2(DEPTH);

  T               mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [AW:0]    count;
  logic           do_pop;

  assign full   = (count == (AW+1)'(DEPTH));
  assign empty  = (count == '0);
  assign dout   = mem[rd_ptr];
  assign do_pop = pop && !empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(push) - (AW+1)'(do_pop);
    end
  end

endmodule

// File: rtl/fadd_issue.sv
// Issue stage for a fixed-latency FP adder: credit-gated accept, delay line, result FIFO.
// Define FADD_ISSUE_EXC_EN to add the per-result out_exc flag.
module fadd_issue
  import fadd_issue_pkg::*;
#(
  parameter int LAT        = 2,
  parameter int TAG_W      = 5,
  parameter int OBUF_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [TAG_W-1:0] in_tag,
  input  logic [31:0]      in_a,
  input  logic [31:0]      in_b,
  output logic [31:0]      add_x1,
  output logic [31:0]      add_x2,
  input  logic [31:0]      add_y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [TAG_W-1:0] out_tag,
`ifdef FADD_ISSUE_EXC_EN
  output logic             out_exc,
`endif
  output logic [31:0]      out_result
);

  localparam int CW = $clog2(OBUF_DEPTH) + 1;

  // Entry structs are sized by the package tag width.
  if (TAG_W != PKG_TAG_W) begin : g_tag_w_check
    $error("fadd_issue: TAG_W must equal fadd_issue_pkg::PKG_TAG_W");
  end

  logic [CW-1:0] credits;
  logic          accept;
  logic          pop;
  op_e           issue_op;
  dl_entry_t     new_entry;
  dl_entry_t     dl [LAT+1];
  buf_entry_t    push_entry;
  buf_entry_t    head;
  logic          fifo_full;
  logic          fifo_empty;

  assign in_ready = !rst && (credits != '0);
  assign accept   = in_valid && in_ready;
  assign pop      = out_valid && out_ready;

  always_comb begin
    issue_op               = op_e'(in_op);
    new_entry              = '0;
    new_entry.valid        = accept;
    new_entry.tag          = in_tag;
    new_entry.bypass       = (issue_op == OP_FNEG) || (issue_op == OP_FABS);
    new_entry.local_result = (issue_op == OP_FNEG) ? {~in_a[31], in_a[30:0]}
                                                   : {1'b0, in_a[30:0]};
`ifdef FADD_ISSUE_EXC_EN
    new_entry.exc          = exp_is_max(in_a) || (!new_entry.bypass && exp_is_max(in_b));
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      credits <= CW'(OBUF_DEPTH);
      add_x1  <= '0;
      add_x2  <= '0;
      for (int i = 0; i <= LAT; i++) dl[i] <= '0;
    end else begin
      if (accept && !pop)      credits <= credits - CW'(1);
      else if (pop && !accept) credits <= credits + CW'(1);
      // Bypass ops leave the adder operands untouched.
      if (accept && !new_entry.bypass) begin
        add_x1 <= in_a;
        add_x2 <= (issue_op == OP_FSUB) ? {~in_b[31], in_b[30:0]} : in_b;
      end
      dl[0] <= new_entry;
      for (int i = 1; i <= LAT; i++) dl[i] <= dl[i-1];
    end
  end

  always_comb begin
    push_entry        = '0;
    push_entry.tag    = dl[LAT].tag;
    push_entry.result = dl[LAT].bypass ? dl[LAT].local_result : add_y;
`ifdef FADD_ISSUE_EXC_EN
    push_entry.exc    = dl[LAT].exc || (!dl[LAT].bypass && exp_is_max(add_y));
`endif
  end

  fadd_issue_fifo #(
    .DEPTH (OBUF_DEPTH),
    .T     (buf_entry_t)
  ) u_obuf (
    .clk   (clk),
    .rst   (rst),
    .push  (dl[LAT].valid),
    .din   (push_entry),
    .pop   (pop),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Credits cover every in-flight op, so a full buffer never sees a write.
  assert property (@(posedge clk) disable iff (rst) !(dl[LAT].valid && fifo_full));

  assign out_valid  = !fifo_empty;
  assign out_tag    = head.tag;
  assign out_result = head.result;
`ifdef FADD_ISSUE_EXC_EN
  assign out_exc    = head.exc;
`endif

endmodule

// File: tb/tb_fadd_issue.sv
// Self-checking bench for fadd_issue: directed vectors, corner sequences, random traffic
// against a scoreboard driven by an ideal adder model. Honours FADD_ISSUE_EXC_EN.
module tb_fadd_issue;
  import fadd_issue_pkg::*;

  localparam int LAT   = 2;
  localparam int TAG_W = 5;
  localparam int DEPTH = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_op;
  logic [TAG_W-1:0] in_tag;
  logic [31:0]      in_a, in_b;
  logic [31:0]      add_x1, add_x2, add_y;
  logic             out_valid;
  logic             out_ready;
  logic [TAG_W-1:0] out_tag;
  logic [31:0]      out_result;
`ifdef FADD_ISSUE_EXC_EN
  logic             out_exc;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fadd_issue #(.LAT(LAT), .TAG_W(TAG_W), .OBUF_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_tag     (in_tag),
    .in_a       (in_a),
    .in_b       (in_b),
    .add_x1     (add_x1),
    .add_x2     (add_x2),
    .add_y      (add_y),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_tag    (out_tag),
`ifdef FADD_ISSUE_EXC_EN
    .out_exc    (out_exc),
`endif
    .out_result (out_result)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---- ideal single-precision adder (small finite values are exact enough) ----
  function automatic real sp_to_real(input logic [31:0] f);
    real r;
    int  e;
    r = 1.0 + real'(f[22:0]) / 8388608.0;
    e = int'(f[30:23]) - 127;
    while (e > 0) begin r = r * 2.0; e--; end
    while (e < 0) begin r = r / 2.0; e++; end
    return f[31] ? -r : r;
  endfunction

  function automatic logic [31:0] real_to_sp(input real v);
    logic s;
    real  r;
    int   e;
    int   m;
    s = (v < 0.0);
    r = s ? -v : v;
    e = 127;
    if (r == 0.0) return 32'h0;
    while (r >= 2.0) begin r = r / 2.0; e++; end
    while (r < 1.0)  begin r = r * 2.0; e--; end
    m = int'((r - 1.0) * 8388608.0);
    if (m >= 8388608) begin m = 0; e++; end
    if (e >= 255) return {s, 8'hFF, 23'h0};
    if (e <= 0)   return {s, 31'h0};
    return {s, e[7:0], m[22:0]};
  endfunction

  function automatic logic [31:0] ideal_add(input logic [31:0] x1, input logic [31:0] x2);
    if (x1[30:23] == 8'h00) return x2;
    if (x2[30:23] == 8'h00) return x1;
    if (x1[30:23] == 8'hFF || x2[30:23] == 8'hFF) return {x1[31], 8'hFF, 23'h0};
    return real_to_sp(sp_to_real(x1) + sp_to_real(x2));
  endfunction

  logic [31:0] apipe [LAT];
  always @(posedge clk) begin
    apipe[0] <= ideal_add(add_x1, add_x2);
    for (int i = 1; i < LAT; i++) apipe[i] <= apipe[i-1];
  end
  assign add_y = apipe[LAT-1];

  // ---- scoreboard ----
  typedef struct {
    logic [TAG_W-1:0] tag;
    logic [31:0]      result;
    logic             exc;
  } exp_t;

  function automatic exp_t ref_op(input logic [1:0] op, input logic [31:0] a,
                                  input logic [31:0] b, input logic [TAG_W-1:0] tag);
    exp_t e;
    e.tag = tag;
    case (op)
      2'b00:   e.result = ideal_add(a, b);
      2'b01:   e.result = ideal_add(a, {~b[31], b[30:0]});
      2'b10:   e.result = {~a[31], a[30:0]};
      default: e.result = {1'b0, a[30:0]};
    endcase
    if (op[1]) e.exc = (a[30:23] == 8'hFF);
    else       e.exc = (a[30:23] == 8'hFF) || (b[30:23] == 8'hFF) || (e.result[30:23] == 8'hFF);
    return e;
  endfunction

  exp_t             sbq [$];
  int               mcred = DEPTH;
  logic             hold_v = 1'b0;
  logic [TAG_W-1:0] hold_tag;
  logic [31:0]      hold_res;

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      check("in_ready_in_reset", in_ready, 0);
      sbq.delete();
      mcred  = DEPTH;
      hold_v = 1'b0;
    end else begin
      check("in_ready_credits", in_ready, (mcred != 0) ? 1 : 0);
      if (hold_v) begin
        check("hold_valid", out_valid, 1);
        check("hold_tag", out_tag, hold_tag);
        check("hold_result", out_result, hold_res);
      end
      if (out_valid && out_ready) begin
        if (sbq.size() == 0) begin
          check("stale_result", out_result, 32'hDEAD_0000);
        end else begin
          e = sbq.pop_front();
          check("sb_tag", out_tag, e.tag);
          check("sb_result", out_result, e.result);
`ifdef FADD_ISSUE_EXC_EN
          check("sb_exc", out_exc, e.exc);
`endif
        end
        mcred++;
      end
      if (in_valid && in_ready) begin
        sbq.push_back(ref_op(in_op, in_a, in_b, in_tag));
        mcred--;
      end
      hold_v   = out_valid && !out_ready;
      hold_tag = out_tag;
      hold_res = out_result;
    end
  end

  // ---- directed vectors ----
  typedef struct {
    logic [1:0]       op;
    logic [31:0]      a, b;
    logic [TAG_W-1:0] tag;
    logic [31:0]      x1, x2;
    logic [31:0]      result;
    logic             exc;
  } vec_t;

  vec_t vecs [9];

  task automatic run_vec(input vec_t v);
    int lat;
    int guard;
    in_valid = 1'b1; in_op = v.op; in_a = v.a; in_b = v.b; in_tag = v.tag;
    guard = 0;
    @(negedge clk);
    while (!in_ready && guard < 20) begin @(negedge clk); guard++; end
    check("vec_accept", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("vec_add_x1", add_x1, v.x1);
    check("vec_add_x2", add_x2, v.x2);
    lat = 1;
    @(negedge clk);
    while (!out_valid && lat < 20) begin @(negedge clk); lat++; end
    check("vec_latency", lat, LAT + 2);
    check("vec_result", out_result, v.result);
    check("vec_tag", out_tag, v.tag);
`ifdef FADD_ISSUE_EXC_EN
    check("vec_exc", out_exc, v.exc);
`endif
    @(posedge clk); #1;
  endtask

  task automatic pulse(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [TAG_W-1:0] tag, output logic took);
    in_valid = 1'b1; in_op = op; in_a = a; in_b = b; in_tag = tag;
    @(negedge clk);
    took = in_ready;
    @(posedge clk); #1;
  endtask

  function automatic logic [31:0] rand_fp();
    logic [7:0] e;
    int sel;
    sel = $urandom_range(0, 15);
    if (sel == 0)      e = 8'h00;
    else if (sel == 1) e = 8'hFF;
    else               e = 8'($urandom_range(110, 140));
    return {1'($urandom_range(0, 1)), e, 23'($urandom)};
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic        took;
    int          acc;
    int          n;
    int          guard;
    logic [31:0] got_r [3];
    logic [31:0] got_t [3];
    logic [31:0] exp_r [3];

    vecs[0] = '{2'b00, 32'h3F800000, 32'h40000000, 5'd3,  32'h3F800000, 32'h40000000, 32'h40400000, 1'b0};
    vecs[1] = '{2'b01, 32'h40400000, 32'h3F800000, 5'd4,  32'h40400000, 32'hBF800000, 32'h40000000, 1'b0};
    vecs[2] = '{2'b10, 32'h3F800000, 32'h12345678, 5'd5,  32'h40400000, 32'hBF800000, 32'hBF800000, 1'b0};
    vecs[3] = '{2'b11, 32'hC0000000, 32'h00000000, 5'd6,  32'h40400000, 32'hBF800000, 32'h40000000, 1'b0};
    vecs[4] = '{2'b00, 32'h00000000, 32'h40A00000, 5'd7,  32'h00000000, 32'h40A00000, 32'h40A00000, 1'b0};
    vecs[5] = '{2'b00, 32'h7F800000, 32'h3F800000, 5'd8,  32'h7F800000, 32'h3F800000, 32'h7F800000, 1'b1};
    vecs[6] = '{2'b00, 32'h7F000000, 32'h7F000000, 5'd9,  32'h7F000000, 32'h7F000000, 32'h7F800000, 1'b1};
    vecs[7] = '{2'b10, 32'hFF800000, 32'h3F800000, 5'd10, 32'h7F000000, 32'h7F000000, 32'h7F800000, 1'b1};
    vecs[8] = '{2'b01, 32'h40A00000, 32'h40400000, 5'd31, 32'h40A00000, 32'hC0400000, 32'h40000000, 1'b0};

    rst = 1'b1; in_valid = 1'b0; in_op = 2'b00; in_tag = '0; in_a = '0; in_b = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_add_x1", add_x1, 0);
    check("rst_add_x2", add_x2, 0);
    check("rst_out_tag", out_tag, 0);
    check("rst_out_result", out_result, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;

    foreach (vecs[i]) run_vec(vecs[i]);

    // back-to-back mixed bypass/adder ops keep order
    acc = 0;
    pulse(2'b10, 32'h3F800000, 32'h0, 5'd1, took); acc += took;
    pulse(2'b00, 32'h3F800000, 32'h3F800000, 5'd2, took); acc += took;
    pulse(2'b11, 32'hC0000000, 32'h0, 5'd3, took); acc += took;
    in_valid = 1'b0;
    check("b2b_accepts", acc, 3);
    n = 0; guard = 0;
    while (n < 3 && guard < 30) begin
      @(negedge clk);
      if (out_valid && out_ready) begin got_r[n] = out_result; got_t[n] = out_tag; n++; end
      guard++;
    end
    @(posedge clk); #1;
    check("b2b_count", n, 3);
    exp_r[0] = 32'hBF800000; exp_r[1] = 32'h40000000; exp_r[2] = 32'h40000000;
    for (int i = 0; i < 3; i++) begin
      check("b2b_result", got_r[i], exp_r[i]);
      check("b2b_tag", got_t[i], i + 1);
    end

    // credit exhaustion under back-pressure
    out_ready = 1'b0; in_valid = 1'b1; in_op = 2'b00; in_a = 32'h3F800000; in_b = 32'h3F800000;
    acc = 0;
    for (int i = 0; i < 12; i++) begin
      in_tag = 5'(i + 11);
      @(negedge clk);
      if (in_ready) acc++;
      @(posedge clk); #1;
    end
    check("credit_accepts", acc, DEPTH);
    @(negedge clk);
    check("credit_full_ready", in_ready, 0);
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(negedge clk);
    check("ready_after_pop", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    check("pop_and_accept", {30'b0, in_ready, out_valid}, 32'd3);
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    check("credits_unchanged", in_ready, 1);
    @(posedge clk); #1;
    out_ready = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    check("credit_drain", sbq.size(), 0);

    // reset with two buffered and two in flight
    out_ready = 1'b0;
    pulse(2'b00, 32'h3F800000, 32'h40000000, 5'd20, took);
    pulse(2'b10, 32'h40400000, 32'h0, 5'd21, took);
    in_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    pulse(2'b11, 32'hC0400000, 32'h0, 5'd22, took);
    pulse(2'b01, 32'h40400000, 32'h3F800000, 5'd23, took);
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("rst_mid_out_valid", out_valid, 0);
    check("rst_mid_in_ready", in_ready, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("rst_release_ready", in_ready, 1);
    n = 0;
    repeat (10) begin @(negedge clk); if (out_valid) n++; end
    check("no_stale_after_rst", n, 0);
    @(posedge clk); #1;

    // random traffic against the scoreboard
    for (int c = 0; c < 400; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_op     = 2'($urandom_range(0, 3));
      in_a      = rand_fp();
      in_b      = rand_fp();
      in_tag    = 5'($urandom);
      out_ready = ($urandom_range(0, 9) < 7);
      @(posedge clk); #1;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("random_drain", sbq.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
